// File: rtl/stall_ctrl_pkg.sv
// ============================================================================
//  Module : stall_ctrl_pkg
//  Desc   : Shared MDU op codes, Tuse encoding and MDU FSM state type.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stall_ctrl_pkg;

  localparam logic [1:0] MD_MULT   = 2'd0;
  localparam logic [1:0] MD_MULTU  = 2'd1;
  localparam logic [1:0] MD_DIV    = 2'd2;
  localparam logic [1:0] MD_DIVU   = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_ctrl_md_busy_fsm.sv
// ============================================================================
//  Module : md_busy_fsm
//  Desc   : MDU busy tracker: IDLE/BUSY FSM with down-counter and done pulse.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_busy_fsm
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [1:0] i_op,
  output logic       o_busy,
  output logic       o_done
);

  localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CW      = $clog2(c_MAX_CYC + 1);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              r_done;
  logic              w_done_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A start seen while BUSY is dropped: state and count are left untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = is_div_op(i_op) ? c_CW'(DIV_CYCLES) : c_CW'(MULT_CYCLES);
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        w_cnt_nxt = r_cnt - c_CW'(1);
        if (r_cnt == c_CW'(1)) begin
          w_state_nxt = MD_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/stall_ctrl.sv
// ============================================================================
//  Module : stall_ctrl
//  Desc   : Hazard detection, MDU sequencing stall and stall-cycle counter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic [4:0]       E_A3,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic [1:0]       M_Tnew,
  input  logic             D_is_md,
  input  logic             E_md_start,
  input  logic [1:0]       E_md_op,
  output logic             PC_WrEn,
  output logic             FD_WrEn,
  output logic             DE_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             w_md_busy;
  logic             w_md_done;
  logic             w_haz_rs;
  logic             w_haz_rt;
  logic             w_haz_md;
  logic             w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_fsm (
    .clk     (clk),
    .reset   (reset),
    .i_start (E_md_start),
    .i_op    (E_md_op),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done)
  );

  // $0 is hardwired, so a zero source index can never be a real dependency.
  assign w_haz_rs = (D_rs != 5'd0) && (D_Tuse_rs != TUSE_NONE) &&
                    (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                     ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));

  assign w_haz_rt = (D_rt != 5'd0) && (D_Tuse_rt != TUSE_NONE) &&
                    (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                     ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));

  assign w_haz_md = D_is_md && (w_md_busy || E_md_start);
  assign w_stall  = w_haz_rs || w_haz_rt || w_haz_md;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Outputs are held in the "advance" state for as long as reset is low.
  assign PC_WrEn   = !reset || !w_stall;
  assign FD_WrEn   = !reset || !w_stall;
  assign DE_flush  = reset && w_stall;
  assign md_busy   = w_md_busy;
  assign md_done   = w_md_done;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard and multiply/divide sequencing controller for the five-stage MIPS core. It decides each cycle whether the F/D pipeline register and PC advance or hold, and whether the D/E register is flushed to inject a bubble. It owns the multi-cycle MDU busy state machine, so HI/LO-dependent instructions wait in D until the MDU finishes. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULT_CYCLES, 5, busy length of mult/multu
- DIV_CYCLES, 10, busy length of div/divu
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- D_rs  input  5  rs field of instruction in D
- D_rt  input  5  rt field of instruction in D
- D_Tuse_rs  input  2  cycles until D needs rs; 3 = unused
- D_Tuse_rt  input  2  cycles until D needs rt; 3 = unused
- E_A3  input  5  destination register of instruction in E
- E_Tnew  input  2  cycles until E result is available
- M_A3  input  5  destination register of instruction in M
- M_Tnew  input  2  cycles until M result is available
- D_is_md  input  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_md_start  input  1  E holds mult/multu/div/divu this cycle
- E_md_op  input  2  0 mult, 1 multu, 2 div, 3 divu
- PC_WrEn  output  1  PC update enable
- FD_WrEn  output  1  F/D register write enable
- DE_flush  output  1  D/E register clear (bubble)
- md_busy  output  1  MDU operation in progress
- md_done  output  1  one-cycle pulse after MDU completion
- stall_cnt  output  CNT_W  total stalled cycles since reset

## Operation
- Data hazard per source s in {rs, rt}: hit when D_s != 0 and D_s == X_A3 and X_Tnew > D_Tuse_s, for X in {E, M}.
- MDU hazard: D_is_md && (md_busy || E_md_start).
- stall = any data hazard or MDU hazard. PC_WrEn = FD_WrEn = !stall; DE_flush = stall.
- Register $0 never causes a hazard.
- MDU FSM states: IDLE, BUSY.
  - IDLE: at a clock edge with E_md_start=1, cnt <= MULT_CYCLES for op 0/1 or DIV_CYCLES for op 2/3; go to BUSY.
  - BUSY: each edge cnt <= cnt-1; at the edge where cnt==1, go to IDLE and set md_done to 1 for the next cycle.
  - E_md_start while BUSY is ignored; state and cnt are unchanged. The stall logic makes this unreachable; verification checks it anyway.
- md_busy = (state == BUSY), registered.
- stall_cnt increments on every edge where stall=1 and saturates at all ones.
- Reset (reset=0), asynchronous, including mid-operation:
  - state -> IDLE, cnt -> 0, md_busy 0, md_done 0, stall_cnt 0.
  - While reset is asserted, combinational outputs are forced to PC_WrEn 1, FD_WrEn 1, DE_flush 0.

## Timing
- Hazard outputs are combinational from inputs in the same cycle, with zero latency.
- md_busy rises the cycle after the start edge and stays high for exactly N cycles (N = 5 or 10).
- md_done is high for exactly one cycle, the first cycle with md_busy=0.
- A D_is_md instruction stalls during the start cycle and all N busy cycles. It advances in the md_done cycle, so there are N+1 stall cycles in total.
- Simultaneous data hazard and MDU hazard counts as a single stall cycle in stall_cnt.
- A new E_md_start in the same cycle md_done is high is legal and starts a new operation.

## Structure
- Shared package/def header holds: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes, TUSE_NONE = 2'd3, FSM state encodings.
- One natural sub-module, md_busy_fsm: IDLE/BUSY FSM, down-counter, md_busy, md_done.
- Top-level stall_ctrl holds the hazard comparators and stall_cnt.

## Test plan
- Set D_rs=8, D_Tuse_rs=0, E_A3=8, E_Tnew=1 -> PC_WrEn=0, FD_WrEn=0, DE_flush=1. Then change D_rs to 0 -> no stall.
- Set D_rt=9, D_Tuse_rt=1, M_A3=9, M_Tnew=1 -> no stall. Set M_Tnew=2 -> stall; stall_cnt +1 per cycle.
- Pulse E_md_start with op=2 for one cycle -> md_busy high for exactly 10 cycles, then md_done high for 1 cycle. With D_is_md held the whole time, stall spans 11 cycles.
- Pulse op=0 start, then assert E_md_start again while busy -> busy length stays 5 and no extra md_done pulse occurs.
- Drop reset to 0 at cycle 3 of a div -> md_busy=0 immediately, stall_cnt=0, PC_WrEn=1. After release, the FSM accepts a new start.
- Preload stall_cnt near saturation (CNT_W=4 build), then hold stall for 20 cycles -> stall_cnt stays at 4'hF.
